// File: rtl/ysyx_22040931_ifu_fetch_buf.sv
// Fetch unit with a credit-limited instruction buffer.
// Owns the fetch PC, drops stale responses after a redirect, feeds decode.
module ysyx_22040931_ifu_fetch_buf #(
    parameter int          PC_W     = 64,
    parameter int          INST_W   = 32,
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              stall,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [PC_W-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [PC_W-1:0] W_RST_PC = RESET_PC[PC_W-1:0];

    logic [PC_W-1:0]   r_fetch_pc;
    logic [PC_W-1:0]   r_rsp_pc;
    logic [CW-1:0]     r_inflight;
    logic [CW-1:0]     r_drop_cnt;
    logic [CW-1:0]     r_count;
    logic [AW-1:0]     r_head;
    logic [AW-1:0]     r_tail;
    logic [PC_W-1:0]   r_pc_q   [DEPTH];
    logic [INST_W-1:0] r_inst_q [DEPTH];

    logic [CW:0] w_credit;
    logic        w_req_fire;
    logic        w_rsp;
    logic        w_push;
    logic        w_pop;

    assign w_credit = {1'b0, r_inflight} + {1'b0, r_count};

    assign imem_req_valid = ~reset & ~stall & ~redirect
                          & (w_credit < (CW + 1)'(DEPTH));
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid & imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored
    assign w_rsp  = imem_rsp_valid & (r_inflight != '0);
    assign w_push = w_rsp & (r_drop_cnt == '0) & ~redirect;

    assign out_valid = (r_count != '0);
    assign out_pc    = r_pc_q[r_head];
    assign out_inst  = r_inst_q[r_head];
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= W_RST_PC;
            r_rsp_pc   <= W_RST_PC;
            r_inflight <= '0;
            r_drop_cnt <= '0;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else if (redirect) begin
            // Everything still outstanding, minus this cycle's answer, is stale
            r_fetch_pc <= redirect_pc;
            r_rsp_pc   <= redirect_pc;
            r_inflight <= r_inflight - CW'(w_rsp);
            r_drop_cnt <= r_inflight - CW'(w_rsp);
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            if (w_req_fire)
                r_fetch_pc <= r_fetch_pc + PC_W'(4);
            if (w_push) begin
                r_rsp_pc <= r_rsp_pc + PC_W'(4);
                r_tail   <= r_tail + AW'(1);
            end
            if (w_rsp && r_drop_cnt != '0)
                r_drop_cnt <= r_drop_cnt - CW'(1);
            if (w_pop)
                r_head <= r_head + AW'(1);
            r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_rsp);
            r_count    <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_q[i]   <= '0;
                r_inst_q[i] <= '0;
            end
        end else if (w_push) begin
            r_pc_q[r_tail]   <= r_rsp_pc;
            r_inst_q[r_tail] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_ysyx_22040931_ifu_fetch_buf.sv
// Scoreboard bench for the fetch buffer: fixed-latency memory model,
// expected {pc, inst} queued on request fire and compared on pop.
module tb_ysyx_22040931_ifu_fetch_buf;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } req_t;

    logic        clock = 0;
    logic        reset;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 0;
    logic [31:0] imem_rsp_data = 0;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;

    logic        redirect2;
    logic [31:0] redirect_pc2;
    logic        req2_valid;
    logic [31:0] req2_addr;
    logic        rsp2_valid = 0;
    logic        f2 = 0;
    logic        out2_valid;
    logic [31:0] out2_pc;
    logic [31:0] out2_inst;

    exp_t exp_q[$];
    req_t mem_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   lat = 1;
    int   fire_cnt = 0;
    int   outst = 0;
    int   n;

    always #5 clock = ~clock;

    ysyx_22040931_ifu_fetch_buf dut (
        .clock          (clock),
        .reset          (reset),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
    );

    ysyx_22040931_ifu_fetch_buf #(
        .PC_W (32)
    ) dut2 (
        .clock          (clock),
        .reset          (reset),
        .redirect       (redirect2),
        .redirect_pc    (redirect_pc2),
        .stall          (stall),
        .imem_req_valid (req2_valid),
        .imem_req_ready (1'b1),
        .imem_req_addr  (req2_addr),
        .imem_rsp_valid (rsp2_valid),
        .imem_rsp_data  (32'h0),
        .out_valid      (out2_valid),
        .out_ready      (1'b1),
        .out_pc         (out2_pc),
        .out_inst       (out2_inst)
    );

    function automatic logic [31:0] mk_inst(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Fixed-latency, in-order memory
    always @(posedge clock) begin
        #1;
        if (reset) begin
            imem_rsp_valid = 0;
        end else if (mem_q.size() > 0 && mem_q[0].due == cyc + 1) begin
            req_t r;
            r = mem_q.pop_front();
            imem_rsp_valid = 1;
            imem_rsp_data  = mk_inst(r.addr);
        end else begin
            imem_rsp_valid = 0;
        end
    end

    // One-cycle memory for the narrow instance
    always @(negedge clock) f2 = req2_valid & ~reset;
    always @(posedge clock) begin
        #1;
        rsp2_valid = f2 & ~reset;
    end

    always @(negedge clock) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_pc", out_pc, e.pc);
                    chk("out_inst", {32'h0, out_inst}, {32'h0, e.inst});
                end
            end
            if (imem_rsp_valid) begin
                assert (outst > 0) else $error("FAIL protocol: response with none outstanding");
                outst--;
            end
            if (imem_req_valid && imem_req_ready) begin
                exp_q.push_back('{imem_req_addr, mk_inst(imem_req_addr)});
                mem_q.push_back('{imem_req_addr, cyc + 1 + lat});
                fire_cnt++;
                outst++;
            end
            if (redirect)
                exp_q.delete();
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 0; stall = 0; redirect = 0; redirect_pc = 0;
        out_ready = 1; imem_req_ready = 1;
        redirect2 = 0; redirect_pc2 = 0;
        #1 reset = 1;
        repeat (3) mid();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_inst", {32'h0, out_inst}, 0);
        chk("rst_req_valid", imem_req_valid, 0);

        tick(); reset = 0;
        mid();
        chk("first_valid", imem_req_valid, 1);
        chk("first_addr", imem_req_addr, 64'h8000_0000);
        tick(); mid();
        chk("lat_n1_valid", out_valid, 0);
        tick(); mid();
        chk("lat_n2_valid", out_valid, 1);
        chk("lat_n2_pc", out_pc, 64'h8000_0000);
        tick(); n = fire_cnt;
        repeat (10) tick();
        chk("throughput", fire_cnt - n, 10);

        redirect2 = 1; redirect_pc2 = 32'hffff_fffc;
        tick(); redirect2 = 0;
        mid();
        chk("wrap_a_valid", req2_valid, 1);
        chk("wrap_a_addr", {32'h0, req2_addr}, 64'hffff_fffc);
        tick(); mid();
        chk("wrap_b_valid", req2_valid, 1);
        chk("wrap_b_addr", {32'h0, req2_addr}, 0);

        tick(); stall = 1;
        repeat (4) tick();
        mid();
        chk("bp_drained", out_valid, 0);
        tick(); stall = 0; out_ready = 0; n = fire_cnt;
        repeat (10) tick();
        chk("bp_fires", fire_cnt - n, 4);
        mid();
        chk("bp_req_valid", imem_req_valid, 0);
        chk("bp_count", dut.r_count, 4);
        tick(); out_ready = 1; n = fire_cnt;
        repeat (12) tick();
        chk("bp_resume", (fire_cnt - n) > 0, 1);

        stall = 1; n = fire_cnt;
        repeat (5) tick();
        chk("stall_nofire", fire_cnt - n, 0);
        mid();
        chk("stall_drain", out_valid, 0);
        tick(); stall = 0;
        repeat (8) tick();

        stall = 1;
        repeat (8) tick();
        lat = 4; stall = 0;
        repeat (3) tick();
        redirect = 1; redirect_pc = 64'h8000_0100;
        mid();
        chk("rd_inflight", dut.r_inflight, 3);
        tick(); redirect = 0;
        mid();
        chk("rd_out_valid", out_valid, 0);
        chk("rd_req_valid", imem_req_valid, 1);
        chk("rd_req_addr", imem_req_addr, 64'h8000_0100);
        chk("rd_drop3", dut.r_drop_cnt, 3);
        repeat (12) tick();
        chk("rd_drop0", dut.r_drop_cnt, 0);

        stall = 1;
        repeat (10) tick();
        lat = 1; stall = 0;
        repeat (6) tick();
        redirect = 1; redirect_pc = 64'h8000_0200;
        mid();
        chk("rp_out_valid", out_valid, 1);
        tick(); redirect = 0;
        mid();
        chk("rp_empty", out_valid, 0);
        chk("rp_count", dut.r_count, 0);
        chk("rp_drop", dut.r_drop_cnt, 0);
        chk("rp_req_addr", imem_req_addr, 64'h8000_0200);
        repeat (8) tick();

        stall = 1;
        repeat (4) tick();
        out_ready = 0; stall = 0;
        repeat (2) tick();
        stall = 1;
        repeat (3) tick();
        mid();
        chk("rst_mid_count", dut.r_count, 2);
        chk("rst_mid_valid", out_valid, 1);
        #2;
        reset = 1;
        mem_q.delete(); exp_q.delete(); outst = 0;
        #1;
        chk("rst_async_valid", out_valid, 0);
        chk("rst_async_req", imem_req_valid, 0);
        tick(); tick();
        reset = 0; stall = 0; out_ready = 1;
        mid();
        chk("restart_valid", imem_req_valid, 1);
        chk("restart_addr", imem_req_addr, 64'h8000_0000);
        repeat (10) tick();

        stall = 1;
        repeat (6) tick();
        chk("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
